// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency-measurement blocks.
//   fm_state_e     : measurement FSM states
//   FM_CNT_W       : default result counter width
//   FM_GATE_1S_50M : default gate length (1 s at 50 MHz)
//   fm_sat_inc     : saturating increment for counters up to 64 bits wide
package freq_meter_pkg;

  localparam int unsigned FM_CNT_W       = 32;
  localparam int unsigned FM_GATE_1S_50M = 50000000;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    CLOSE,
    DONE
  } fm_state_e;

  // v + 1, clamped at 2^w - 1. Callers zero-extend their counter to 64 bits
  // and truncate the result back to their own width.
  function automatic logic [63:0] fm_sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Synchroniser plus rising-edge detector for an asynchronous input.
//   clk, reset (async, active low), din (async input)
//   rise : one-cycle pulse, SYNC_STAGES+1 cycles after the din edge
module sig_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;

  // rise is registered so downstream sees a clean, glitch-free pulse; this
  // accounts for the extra cycle of latency beyond the synchroniser depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
      sync_prev <= sync_q[SYNC_STAGES-1];
      rise      <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

endmodule

// File: rtl/recip_freq_meter.sv
// Reciprocal (equal-precision) frequency meter. The gate opens and closes on
// synchronised sig rising edges, so sig_count is an exact number of whole
// periods spanning ref_count clk cycles: f_sig = f_clk * sig_count / ref_count.
//   clk, reset (async, active low), sig (async), start (1-cycle request)
//   busy, done (1-cycle, results valid), ref_count, sig_count,
//   overflow (a counter saturated), timeout (no sig edge in time)
// Optional: define RECIP_FREQ_METER_TIMEOUT_EN to abort after TIMEOUT_CYCLES
// without an edge in ARM or CLOSE; otherwise timeout is tied to 0.
module recip_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W          = FM_CNT_W,
  parameter int unsigned GATE_CYCLES    = FM_GATE_1S_50M,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ref_count,
  output logic [CNT_W-1:0] sig_count,
  output logic             overflow,
  output logic             timeout
);

  if (GATE_CYCLES < 2 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || CNT_W > 64) begin : g_param_err
    $error("recip_freq_meter: illegal parameter value");
  end

  localparam int unsigned      TMR_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             rise;
  fm_state_e        state;
  logic [CNT_W-1:0] ref_cnt, sig_cnt, ref_nxt, sig_nxt;
  logic [TMR_W-1:0] timer;
  logic             sticky;
  logic             ovf_now;

  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (sig),
    .rise (rise)
  );

  assign ref_nxt = CNT_W'(fm_sat_inc(64'(ref_cnt), CNT_W));
  assign sig_nxt = CNT_W'(fm_sat_inc(64'(sig_cnt), CNT_W));
  // A counter already at max that is asked to count this cycle saturates.
  assign ovf_now = (ref_cnt == CNT_MAX) | (rise & (sig_cnt == CNT_MAX));

`ifdef RECIP_FREQ_METER_TIMEOUT_EN
  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_exp;
  assign wait_exp = (wait_cnt == WAIT_LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ref_cnt   <= '0;
      sig_cnt   <= '0;
      timer     <= '0;
      sticky    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ref_count <= '0;
      sig_count <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ref_cnt <= '0;
          sig_cnt <= '0;
          timer   <= '0;
          sticky  <= 1'b0;
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            overflow <= 1'b0;
            timeout  <= 1'b0;
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        // Opening edge: counters are still zero and it is not counted.
        ARM: begin
          if (rise) state <= MEASURE;
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
          else if (wait_exp) begin
            state     <= DONE;
            done      <= 1'b1;
            ref_count <= '0;
            sig_count <= '0;
            overflow  <= sticky;
            timeout   <= 1'b1;
          end
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        MEASURE: begin
          ref_cnt <= ref_nxt;
          if (rise) sig_cnt <= sig_nxt;
          sticky <= sticky | ovf_now;
          timer  <= timer + 1'b1;
          // Timer reaches GATE_CYCLES at the end of this cycle; an edge here
          // is counted but cannot close the gate.
          if (timer == TMR_LAST) begin
            state <= CLOSE;
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        CLOSE: begin
          ref_cnt <= ref_nxt;
          if (rise) begin
            // Closing edge: load results including this cycle's increments.
            sig_cnt   <= sig_nxt;
            state     <= DONE;
            done      <= 1'b1;
            ref_count <= ref_nxt;
            sig_count <= sig_nxt;
            overflow  <= sticky | ovf_now;
          end else begin
            sticky <= sticky | ovf_now;
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
            if (wait_exp) begin
              state     <= DONE;
              done      <= 1'b1;
              ref_count <= '0;
              sig_count <= '0;
              overflow  <= sticky | ovf_now;
              timeout   <= 1'b1;
            end
`endif
          end
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef RECIP_FREQ_METER_TIMEOUT_EN
  logic unused_tie;
  assign unused_tie = 1'b0;
`endif

endmodule

// File: tb/tb_recip_freq_meter.sv
// Self-checking bench for recip_freq_meter. Four instances with different
// widths/gates share clk, sig and start. sig is driven from a precomputed
// waveform, so the expected result of every accepted start is computed from
// the list of future synchronised edges with plain arithmetic.
module tb_recip_freq_meter;

  localparam int NI   = 4;
  localparam int SS   = 2;
  localparam int LAT  = SS + 1;
  localparam int TOC  = 50;
  localparam int MAXC = 40000;
  localparam int WV [NI] = '{32, 8, 8, 32};
  localparam int GV [NI] = '{100, 300, 100, 1000};

  logic clk = 1'b0;
  logic reset, start, sig;
  logic sig_s = 1'b0, sig_a = 1'b0;
  bit   async_mode = 1'b0;
  int   cyc = 0, tests = 0, fails = 0;
  bit   wave [MAXC];

  logic        d_busy [NI], d_done [NI], d_ovf [NI], d_to [NI];
  logic [31:0] d_ref [NI], d_sig [NI];

  // model state per instance
  int          bfrom [NI], buntil [NI], clr_at [NI];
  logic [31:0] p_ref [NI], p_sig [NI], e_ref [NI], e_sig [NI];
  bit          p_ovf [NI], p_to [NI], e_ovf [NI], e_to [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [WV[g]-1:0] r, s;
    recip_freq_meter #(
      .CNT_W(WV[g]), .GATE_CYCLES(GV[g]), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TOC)
    ) u_dut (
      .clk(clk), .reset(reset), .sig(sig), .start(start),
      .busy(d_busy[g]), .done(d_done[g]), .ref_count(r), .sig_count(s),
      .overflow(d_ovf[g]), .timeout(d_to[g])
    );
    assign d_ref[g] = 32'(r);
    assign d_sig[g] = 32'(s);
  end

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) sig_s = (cyc < MAXC) ? wave[cyc] : 1'b0;
  always #133 if (async_mode) sig_a = ~sig_a;   // 266 time units = 13.3 clk
  assign sig = async_mode ? sig_a : sig_s;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
    end
  endtask

  // A synchronised rise is seen LAT cycles after the cycle sig went 0->1.
  function automatic bit rise_at(input int n);
    if (n - LAT - 1 < 0 || n - LAT >= MAXC) return 1'b0;
    return wave[n-LAT] && !wave[n-LAT-1];
  endfunction

  function automatic longint rises_in(input int a, input int b);  // (a, b]
    longint c = 0;
    for (int n = a + 1; n <= b; n++) if (rise_at(n)) c++;
    return c;
  endfunction

  task automatic set_wave(input int from, input int p);
    for (int n = from; n < MAXC; n++)
      wave[n] = (p == 0) ? 1'b0 : (((n - from) % p) < (p / 2));
  endtask

  // Start seen in cycle s: compute what each idle instance must report.
  task automatic model_start(input int s);
    for (int i = 0; i < NI; i++) begin
      int t0, cl, dn;
      longint r, sc, mx;
      bit to;
      if (s >= bfrom[i] && s <= buntil[i]) continue;
      mx = (WV[i] == 32) ? 64'hFFFF_FFFF : 64'd255;
      t0 = -1; cl = -1; to = 1'b0; r = 0; sc = 0; dn = s + 1;
      for (int n = s + 1; n < MAXC; n++) if (rise_at(n)) begin t0 = n; break; end
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
      if (t0 < 0 || t0 - (s + 1) >= TOC) begin to = 1'b1; dn = s + 1 + TOC; end
`endif
      if (!to && t0 >= 0) begin
        for (int n = t0 + GV[i] + 1; n < MAXC; n++) if (rise_at(n)) begin cl = n; break; end
`ifdef RECIP_FREQ_METER_TIMEOUT_EN
        if (cl < 0 || cl - (t0 + GV[i] + 1) >= TOC) begin
          to = 1'b1; dn = t0 + GV[i] + 1 + TOC;
          r = dn - 1 - t0; sc = rises_in(t0, t0 + GV[i]);
        end
`endif
        if (!to && cl >= 0) begin dn = cl + 1; r = cl - t0; sc = rises_in(t0, cl); end
      end
      if (!to && (t0 < 0 || cl < 0)) begin
        tests++; fails++;
        $display("FAIL model_range[%0d] cyc=%0d got=no_edge want=edge", i, s);
      end
      bfrom[i]  = s + 1;
      buntil[i] = dn;
      clr_at[i] = s + 1;
      p_to[i]   = to;
      p_ovf[i]  = (r > mx) || (sc > mx);
      p_ref[i]  = to ? 32'd0 : 32'((r > mx) ? mx : r);
      p_sig[i]  = to ? 32'd0 : 32'((sc > mx) ? mx : sc);
    end
  endtask

  // Compare every instance against the model every cycle.
  always @(posedge clk) begin : cmp
    bit eb, ed;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (async_mode) begin
        tests++;
        if ($isunknown({d_busy[i], d_done[i], d_ovf[i], d_to[i], d_ref[i], d_sig[i]})) begin
          fails++;
          $display("FAIL xcheck[%0d] cyc=%0d got=X want=known", i, cyc);
        end
      end else begin
        if (!reset) begin
          bfrom[i] = 1; buntil[i] = 0; clr_at[i] = -1;
          e_ref[i] = 0; e_sig[i] = 0; e_ovf[i] = 0; e_to[i] = 0;
        end else begin
          if (cyc == clr_at[i]) begin e_ovf[i] = 0; e_to[i] = 0; end
          if (cyc == buntil[i]) begin
            e_ref[i] = p_ref[i]; e_sig[i] = p_sig[i];
            e_ovf[i] = p_ovf[i]; e_to[i] = p_to[i];
          end
        end
        eb = reset && (cyc >= bfrom[i]) && (cyc <= buntil[i]);
        ed = eb && (cyc == buntil[i]);
        chk("busy", i, 32'(d_busy[i]), 32'(eb));
        chk("done", i, 32'(d_done[i]), 32'(ed));
        chk("ref_count", i, d_ref[i], e_ref[i]);
        chk("sig_count", i, d_sig[i], e_sig[i]);
        chk("overflow", i, 32'(d_ovf[i]), 32'(e_ovf[i]));
        chk("timeout", i, 32'(d_to[i]), 32'(e_to[i]));
      end
    end
  end

  function automatic bit busy_any();
    for (int i = 0; i < NI; i++) if (cyc <= buntil[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    if (!async_mode) model_start(cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy_any() && g < 5000) begin @(negedge clk); g++; end
    tests++;
    if (g >= 5000) begin fails++; $display("FAIL wait_idle cyc=%0d got=busy want=idle", cyc); end
    repeat (2) @(negedge clk);
  endtask

  // One measurement with period p; optionally pulse start again exactly in
  // instance 0's DONE cycle, which must be ignored.
  task automatic run_meas(input int p, input bit start_in_done);
    set_wave(cyc + 2 + $urandom_range(0, p), p);
    repeat ($urandom_range(3, 8)) @(negedge clk);
    pulse_start();
    if (start_in_done) begin
      while (cyc < buntil[0]) @(negedge clk);
      pulse_start();
    end
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      bfrom[i] = 1; buntil[i] = 0; clr_at[i] = -1;
      e_ref[i] = 0; e_sig[i] = 0; e_ovf[i] = 0; e_to[i] = 0;
    end
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("rst_ref", i, d_ref[i], 32'd0);

    // period 7, gate 100: 14 edges inside, closing edge at +105
    run_meas(7, 1'b0);
    chk("lit_p7_sig", 0, d_sig[0], 32'd15);
    chk("lit_p7_ref", 0, d_ref[0], 32'd105);
    chk("lit_p7_ovf", 0, 32'(d_ovf[0]), 32'd0);

    // period 10: edge on the last gate cycle counted, next one closes
    run_meas(10, 1'b1);
    chk("lit_p10_sig", 0, d_sig[0], 32'd11);
    chk("lit_p10_ref", 0, d_ref[0], 32'd110);

    // period 5: 8-bit/300 saturates ref; 8-bit/100 fits
    run_meas(5, 1'b0);
    chk("lit_sat_ref", 1, d_ref[1], 32'd255);
    chk("lit_sat_sig", 1, d_sig[1], 32'd61);
    chk("lit_sat_ovf", 1, 32'(d_ovf[1]), 32'd1);
    chk("lit_fit_ref", 2, d_ref[2], 32'd105);
    chk("lit_fit_sig", 2, d_sig[2], 32'd21);
    chk("lit_fit_ovf", 2, 32'(d_ovf[2]), 32'd0);

    // start while busy, then a 1-cycle reset mid-measurement
    set_wave(cyc + 2, 9);
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("abort_busy", i, 32'(d_busy[i]), 32'd0);
      chk("abort_sig", i, d_sig[i], 32'd0);
    end
    repeat (40) @(negedge clk);
    run_meas(7, 1'b0);
    chk("lit_after_rst_sig", 0, d_sig[0], 32'd15);
    chk("lit_after_rst_ref", 0, d_ref[0], 32'd105);

    for (int k = 0; k < 10; k++) run_meas($urandom_range(3, 25), 1'b0);

`ifdef RECIP_FREQ_METER_TIMEOUT_EN
    set_wave(cyc + 2, 0);
    repeat (10) @(negedge clk);
    pulse_start();
    wait_idle();
    chk("lit_to", 0, 32'(d_to[0]), 32'd1);
    chk("lit_to_ref", 0, d_ref[0], 32'd0);
`endif

    // asynchronous sig, 13.3 clk period, on the 1000-cycle gate instance
    async_mode = 1'b1;
    repeat (50) @(negedge clk);
    pulse_start();
    begin
      int g = 0;
      while (!d_done[3] && g < 4000) begin @(negedge clk); g++; end
      tests++;
      if (g >= 4000 || d_sig[3] == 0 || 64'(d_ref[3]) * 10 < 64'(d_sig[3]) * 132 ||
          64'(d_ref[3]) * 10 > 64'(d_sig[3]) * 134) begin
        fails++;
        $display("FAIL async_ratio cyc=%0d got=%0d/%0d want=13.3+-0.1", cyc, d_ref[3], d_sig[3]);
      end
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/recip_freq_meter.md
Name: recip_freq_meter

Overview:
- Reciprocal (equal-precision) frequency meter, fully synchronous to `clk`.
- Successor to the free-running direct counter: the gate opens and closes on `sig` rising edges, so the count of signal periods carries no ±1 error.
- Counts whole `sig` periods (`sig_count`) and reference clocks (`ref_count`) over a gate of at least `GATE_CYCLES`.
- Downstream logic or a soft CPU computes f_sig = f_clk × `sig_count` / `ref_count`.

Parameters:
- `CNT_W`, 32: width of both result counters.
- `GATE_CYCLES`, 50000000: minimum gate length in `clk` cycles (1 s at 50 MHz); must be ≥ 2.
- `SYNC_STAGES`, 2: flip-flop stages in the `sig` synchroniser; must be ≥ 2.
- `TIMEOUT_CYCLES`, 100000000: maximum wait for a `sig` edge. Used only with the optional feature.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `sig`, in, 1: asynchronous signal under test.
- `start`, in, 1: one-cycle request to begin a measurement.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse; results are valid in this cycle.
- `ref_count`, out, `CNT_W`: `clk` cycles within the gate.
- `sig_count`, out, `CNT_W`: `sig` rising edges within the gate (equals whole periods).
- `overflow`, out, 1: a counter saturated during the last measurement.
- `timeout`, out, 1: last measurement aborted for lack of `sig` edges. Tied to 0 without the macro.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - FSM goes to IDLE; all internal counters and synchroniser flops clear.
  - `busy`, `done`, `ref_count`, `sig_count`, `overflow` and `timeout` all go to 0.
- Reset mid-measurement aborts the measurement; no `done` pulse is produced.
- Synchroniser and edge detect:
  - `sig` passes through `SYNC_STAGES` flops.
  - `rise` = sync_out & ~sync_prev, giving a one-cycle pulse.
  - Latency from a `sig` edge to `rise` is `SYNC_STAGES`+1 cycles. All timing below is relative to `rise`.
- FSM states: IDLE → ARM → MEASURE → CLOSE → DONE → IDLE.
- IDLE:
  - `start` = 1 moves to ARM.
  - Internal counters and the gate timer clear.
  - `overflow` and `timeout` clear in the same cycle.
- ARM:
  - Waits for `rise`. Call the cycle in which `rise` is seen t0; the gate opens here.
  - Internal ref_cnt, sig_cnt and timer are 0 at t0.
  - At t0 the FSM moves to MEASURE.
  - The opening edge is NOT counted.
- MEASURE (cycles t0+1 … t0+`GATE_CYCLES`):
  - Each cycle: ref_cnt +1 and timer +1.
  - Each `rise`: sig_cnt +1.
  - When timer reaches `GATE_CYCLES`, move to CLOSE.
  - A `rise` in that final cycle is counted but does not close the gate.
- CLOSE:
  - Each cycle: ref_cnt +1.
  - The first `rise` is counted (sig_cnt +1) and closes the gate; move to DONE.
- DONE (exactly one cycle):
  - `ref_count` and `sig_count` are loaded from the internal counters.
  - `done` = 1; next state is IDLE.
- Result identity: `ref_count` = cycles from t0+1 to the closing-edge cycle inclusive, i.e. exactly `sig_count` whole periods.
- Outputs hold their values until the next DONE or reset.
- `start` while `busy` is ignored.
- `start` in the DONE cycle is ignored; it is accepted only in IDLE.
- Saturation:
  - Each internal counter saturates at 2^`CNT_W`−1.
  - Any saturation sets an internal sticky flag, copied to `overflow` in DONE.
  - Counting continues to the closing edge with saturated values.
- `busy` = 1 in ARM, MEASURE, CLOSE and DONE.
- A `sig` that is stuck with no edges hangs the FSM in ARM or CLOSE unless the optional feature is enabled. Only a reset recovers it.

Optional Feature:
- Macro `RECIP_FREQ_METER_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entry to ARM and on entry to CLOSE, and increments each cycle in those states.
  - On reaching `TIMEOUT_CYCLES` with no `rise`, go to DONE with `timeout` = 1 and `ref_count` = `sig_count` = 0; `overflow` follows the sticky flag.
- Undefined: no wait counter exists; `timeout` is constant 0; a stuck input hangs the FSM as described above.

Decomposition:
- Shared package `freq_meter_pkg`:
  - State enum (IDLE, ARM, MEASURE, CLOSE, DONE).
  - Default constants `FM_CNT_W` = 32 and `FM_GATE_1S_50M` = 50000000.
  - Saturating-increment function.
- One natural sub-module, `sig_sync_edge`:
  - Parameter: `SYNC_STAGES`.
  - Inputs: `clk`, `reset`, async in. Output: one-cycle `rise` pulse.
  - Shared with existing measurement blocks.

Test Plan:
1. `GATE_CYCLES` = 100, `sig` period 7 clk → `done` once; `sig_count` = 15, `ref_count` = 105, `overflow` = 0.
2. `GATE_CYCLES` = 100, period 10 (an edge lands on the last MEASURE cycle) → `sig_count` = 11, `ref_count` = 110.
3. `CNT_W` = 8, `GATE_CYCLES` = 300, period 5 → `ref_count` = 255, `sig_count` = 61, `overflow` = 1. Next measurement with `GATE_CYCLES` fitting in 8 bits → `overflow` = 0.
4. `start` pulsed during MEASURE, plus `reset` low for 1 cycle mid-MEASURE → no `done`; all outputs 0; `busy` = 0; a new `start` measures correctly.
5. Macro defined, `TIMEOUT_CYCLES` = 50, `sig` held at 0, `start` → `done` after 50 ARM cycles; `timeout` = 1; counts 0.
6. `sig` changes asynchronously near `clk` edges, period 13.3 clk average, `GATE_CYCLES` = 1000 → `ref_count` / `sig_count` within 13.3 ± 0.1; no X on any output.
